// File: rtl/cpu_pkg.sv
// Shared load-path definitions: op and error encodings, sequencer state type,
// and op legality/alignment helpers.
package cpu_pkg;

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LW  = 3'b010;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_LHU = 3'b101;

   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {StIdle, StReq, StWb, StErr} state_e;

   function automatic logic op_legal(input logic [2:0] op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   endfunction

   function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
      case (op)
         OP_LH, OP_LHU: return off[0];
         OP_LW:         return off != 2'b00;
         default:       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_seq_ctrl_if.sv
// Word-wide data memory read port: request/address from the sequencer,
// ready/data back from memory.
interface load_seq_ctrl_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic [31:0]       mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_ready, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_rdata);
endinterface

// File: rtl/load_extend.sv
// Lane select plus sign/zero extension of a little-endian memory word.
module load_extend
   import cpu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  op,
   output logic [31:0] data32
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = word[{off, 3'b000} +: 8];
      half_lane = word[{off[1], 4'b0000} +: 16];
      case (op)
         OP_LB:   data32 = {{24{byte_lane[7]}}, byte_lane};
         OP_LBU:  data32 = {24'b0, byte_lane};
         OP_LH:   data32 = {{16{half_lane[15]}}, half_lane};
         OP_LHU:  data32 = {16'b0, half_lane};
         default: data32 = word;
      endcase
   end

endmodule

// File: rtl/load_seq_ctrl.sv
// Load sequencer: one outstanding word read per load, lane extraction and
// extension, and a one-cycle writeback or error pulse.
module load_seq_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [4:0]        rd,
   output logic              busy,
   load_seq_ctrl_if.master   mem,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

   state_e            state_q;
   logic [2:0]        op_q;
   logic [1:0]        off_q;
   logic [4:0]        rd_q;
   logic [7:0]        cnt_q;
   logic              mem_req_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       ext_data;
   logic [7:0]        cnt_next;

   load_extend u_extend (
      .word   (mem.mem_rdata),
      .off    (off_q),
      .op     (op_q),
      .data32 (ext_data)
   );

   assign mem.mem_req  = mem_req_q;
   assign mem.mem_addr = mem_addr_q;
   assign cnt_next     = cnt_q + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         op_q       <= 3'b0;
         off_q      <= 2'b0;
         rd_q       <= 5'b0;
         cnt_q      <= 8'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         busy       <= 1'b0;
         wb_valid   <= 1'b0;
         wb_rd      <= 5'b0;
         wb_data    <= 32'b0;
         err        <= 1'b0;
         err_code   <= 2'b0;
      end else begin
         wb_valid <= 1'b0;
         err      <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  busy <= 1'b1;
                  if (!op_legal(op)) begin
                     err_code <= ERR_ILLEGAL;
                     err      <= 1'b1;
                     state_q  <= StErr;
                  end else if (op_misaligned(op, addr[1:0])) begin
                     err_code <= ERR_MISALIGN;
                     err      <= 1'b1;
                     state_q  <= StErr;
                  end else begin
                     op_q       <= op;
                     off_q      <= addr[1:0];
                     rd_q       <= rd;
                     cnt_q      <= 8'b0;
                     mem_addr_q <= {addr[ADDR_W-1:2], 2'b00};
                     mem_req_q  <= 1'b1;
                     state_q    <= StReq;
                  end
               end
            end
            StReq: begin
               // A ready arriving on the expiry cycle still completes the load.
               if (mem.mem_ready) begin
                  wb_data   <= ext_data;
                  wb_rd     <= rd_q;
                  wb_valid  <= 1'b1;
                  mem_req_q <= 1'b0;
                  state_q   <= StWb;
               end else if (cnt_next == TimeoutVal) begin
                  cnt_q     <= cnt_next;
                  err_code  <= ERR_TIMEOUT;
                  err       <= 1'b1;
                  mem_req_q <= 1'b0;
                  state_q   <= StErr;
               end else begin
                  cnt_q <= cnt_next;
               end
            end
            StWb, StErr: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_seq_ctrl.sv
// Directed bench for load_seq_ctrl, built with a 4-cycle memory timeout.
module tb_load_seq_ctrl;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [4:0]  rd;
   logic        busy;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        err;
   logic [1:0]  err_code;
   int          checks = 0;
   int          errors = 0;

   load_seq_ctrl_if #(.ADDR_W(32)) mem_if ();

   load_seq_ctrl #(
      .TIMEOUT_CYCLES (4),
      .ADDR_W         (32)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .addr     (addr),
      .rd       (rd),
      .busy     (busy),
      .mem      (mem_if.master),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .err      (err),
      .err_code (err_code)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_if.mem_req); end
      checks++; if (mem_if.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_if.mem_addr); end
      checks++; if (wb_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_pulses got wb_valid=%b err=%b want 0/0", wb_valid, err); end
      checks++; if (wb_rd !== 5'd0 || wb_data !== 32'h0 || err_code !== 2'b00) begin
         errors++; $display("FAIL reset_data got rd=%0d data=%h code=%b want 0", wb_rd, wb_data, err_code);
      end
   endtask

   task automatic test_lb();
      start = 1'b1; op = OP_LB; addr = 32'h1003; rd = 5'd5;
      next_cycle();  // cycle 1
      start = 1'b0;
      checks++; if (busy !== 1'b1 || mem_if.mem_req !== 1'b1) begin errors++; $display("FAIL lb_c1_req got busy=%b req=%b want 1/1", busy, mem_if.mem_req); end
      checks++; if (mem_if.mem_addr !== 32'h1000) begin errors++; $display("FAIL lb_mem_addr got %h want 00001000", mem_if.mem_addr); end
      mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h80FF_1234;
      next_cycle();  // cycle 2
      mem_if.mem_ready = 1'b0;
      checks++; if (wb_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL lb_c2_wb got wb_valid=%b busy=%b want 1/1", wb_valid, busy); end
      checks++; if (wb_data !== 32'hFFFF_FF80 || wb_rd !== 5'd5) begin errors++; $display("FAIL lb_data got %h rd=%0d want ffffff80 rd=5", wb_data, wb_rd); end
      next_cycle();  // cycle 3
      checks++; if (busy !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL lb_c3_idle got busy=%b wb_valid=%b want 0/0", busy, wb_valid); end
      checks++; if (wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_hold got %h want ffffff80", wb_data); end
   endtask

   // ready held low for three REQ cycles, then high on the cycle the counter would expire
   task automatic test_slow(input logic [2:0] t_op, input logic [31:0] exp, input string name);
      start = 1'b1; op = t_op; addr = 32'h2002; rd = 5'd9;
      mem_if.mem_rdata = 32'h9ABC_0000;
      next_cycle();
      start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h2000 || wb_valid !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL %s_wait%0d got req=%b addr=%h wb=%b err=%b want 1/00002000/0/0",
                               name, c, mem_if.mem_req, mem_if.mem_addr, wb_valid, err);
         end
         if (c < 3) next_cycle();
      end
      next_cycle();  // cycle 4
      checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h2000) begin errors++; $display("FAIL %s_c4 got req=%b addr=%h want 1/00002000", name, mem_if.mem_req, mem_if.mem_addr); end
      mem_if.mem_ready = 1'b1;
      next_cycle();  // cycle 5
      mem_if.mem_ready = 1'b0;
      checks++; if (wb_valid !== 1'b1 || err !== 1'b0 || wb_data !== exp || wb_rd !== 5'd9) begin
         errors++; $display("FAIL %s_wb got wb=%b err=%b data=%h rd=%0d want 1/0/%h/9", name, wb_valid, err, wb_data, wb_rd, exp);
      end
      next_cycle();
      checks++; if (busy !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL %s_done got busy=%b wb=%b want 0/0", name, busy, wb_valid); end
   endtask

   task automatic test_error(input logic [2:0] t_op, input logic [31:0] t_addr,
                             input logic [1:0] exp_code, input string name);
      start = 1'b1; op = t_op; addr = t_addr; rd = 5'd3;
      next_cycle();
      start = 1'b0;
      checks++; if (err !== 1'b1 || err_code !== exp_code || busy !== 1'b1) begin
         errors++; $display("FAIL %s_err got err=%b code=%b busy=%b want 1/%b/1", name, err, err_code, busy, exp_code);
      end
      checks++; if (mem_if.mem_req !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL %s_noreq got req=%b wb=%b want 0/0", name, mem_if.mem_req, wb_valid); end
      next_cycle();
      checks++; if (err !== 1'b0 || busy !== 1'b0 || mem_if.mem_req !== 1'b0) begin
         errors++; $display("FAIL %s_after got err=%b busy=%b req=%b want 0/0/0", name, err, busy, mem_if.mem_req);
      end
   endtask

   task automatic test_timeout();
      start = 1'b1; op = OP_LW; addr = 32'h40; rd = 5'd4;
      mem_if.mem_ready = 1'b0;
      next_cycle();
      // a second request while busy must be dropped
      op = OP_LB; addr = 32'h81;
      for (int c = 1; c <= 4; c++) begin
         checks++; if (mem_if.mem_req !== 1'b1 || err !== 1'b0 || mem_if.mem_addr !== 32'h40) begin
            errors++; $display("FAIL to_req%0d got req=%b err=%b addr=%h want 1/0/00000040", c, mem_if.mem_req, err, mem_if.mem_addr);
         end
         if (c == 2) start = 1'b0;
         next_cycle();
      end
      checks++; if (err !== 1'b1 || err_code !== ERR_TIMEOUT || mem_if.mem_req !== 1'b0 || wb_valid !== 1'b0) begin
         errors++; $display("FAIL to_err got err=%b code=%b req=%b wb=%b want 1/11/0/0", err, err_code, mem_if.mem_req, wb_valid);
      end
      next_cycle();
      checks++; if (busy !== 1'b0 || err !== 1'b0 || mem_if.mem_req !== 1'b0) begin
         errors++; $display("FAIL to_idle got busy=%b err=%b req=%b want 0/0/0", busy, err, mem_if.mem_req);
      end
      next_cycle();
      checks++; if (busy !== 1'b0 || mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL to_noqueue got busy=%b req=%b want 0/0", busy, mem_if.mem_req); end
   endtask

   task automatic test_reset_mid();
      start = 1'b1; op = OP_LW; addr = 32'h100; rd = 5'd6;
      next_cycle();
      start = 1'b0;
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h1111_2222;
      checks++; if (busy !== 1'b0 || mem_if.mem_req !== 1'b0 || mem_if.mem_addr !== 32'h0) begin
         errors++; $display("FAIL rst_mid_bus got busy=%b req=%b addr=%h want 0/0/0", busy, mem_if.mem_req, mem_if.mem_addr);
      end
      checks++; if (wb_data !== 32'h0 || wb_rd !== 5'd0 || err_code !== 2'b00 || err !== 1'b0) begin
         errors++; $display("FAIL rst_mid_out got data=%h rd=%0d code=%b err=%b want 0", wb_data, wb_rd, err_code, err);
      end
      next_cycle();
      mem_if.mem_ready = 1'b0;
      checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_nowb got wb=%b busy=%b want 0/0", wb_valid, busy); end
      start = 1'b1; op = OP_LW; addr = 32'h0; rd = 5'd7;
      next_cycle();
      start = 1'b0;
      checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_lw_req got req=%b addr=%h want 1/0", mem_if.mem_req, mem_if.mem_addr); end
      mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'hDEAD_BEEF;
      next_cycle();
      mem_if.mem_ready = 1'b0;
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_rd !== 5'd7) begin
         errors++; $display("FAIL rst_lw_wb got wb=%b data=%h rd=%0d want 1/deadbeef/7", wb_valid, wb_data, wb_rd);
      end
      next_cycle();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 3'b0; addr = 32'h0; rd = 5'd0;
      mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_lb();
      test_slow(OP_LHU, 32'h0000_9ABC, "lhu");
      test_slow(OP_LH,  32'hFFFF_9ABC, "lh");
      test_slow(OP_LBU, 32'h0000_00BC, "lbu");
      test_error(OP_LW, 32'h0000_0006, ERR_MISALIGN, "lw_mis");
      test_error(OP_LHU, 32'h0000_0003, ERR_MISALIGN, "lhu_mis");
      test_error(3'b011, 32'h0000_0006, ERR_ILLEGAL, "illegal");
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
